// File: rtl/s8sp_pkg.sv
// rtl/s8sp_pkg.sv - shared types, bus defaults and parity helper for the s8sp memory slave
package s8sp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        HOLD
    } mem_state_t;

    // Even parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/s8sp_mem_array.sv
// rtl/s8sp_mem_array.sv - single-port RAM, synchronous write, registered read, contents not reset
module s8sp_mem_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/s8sp_mem_slave.sv
// rtl/s8sp_mem_slave.sv - s8sp bus memory slave with wait states, rdy handshake and range check
// Optional stored-parity check enabled by defining S8SP_MEM_PARITY_EN.
module s8sp_mem_slave
    import s8sp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] dat_in,
    output logic [DATA_W-1:0] dat_out,
    output logic              dat_oe,
    input  logic              rd,
    input  logic              wrt,
    output logic              rdy,
    output logic              err
);

`ifdef S8SP_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WS_LAST = 4'(WAIT_STATES - 1);

    mem_state_t        state, state_nxt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              is_rd_q;
    logic              ill_q;
    logic              in_range;
    logic              par_bad;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;

    assign in_range = {1'b0, addr_q} < DEPTH_L;

`ifdef S8SP_MEM_PARITY_EN
    assign mem_wdata = {even_parity(64'(data_q)), data_q};
    assign par_bad   = even_parity(64'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W];
`else
    assign mem_wdata = data_q;
    assign par_bad   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rd && wrt) begin
                    state_nxt = HOLD;
                end else if (rd || wrt) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!rd && !wrt) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == WS_LAST) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = HOLD;
            HOLD: begin
                if (!rd && !wrt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE the RAM reads the live address so data is ready in the ACCESS cycle even with no wait states.
    always_comb begin
        mem_we   = (state == ACCESS) && !is_rd_q && in_range;
        mem_addr = (state == IDLE) ? add : addr_q;
        err      = ill_q || ((state == ACCESS) && (!in_range || (is_rd_q && par_bad)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            is_rd_q  <= 1'b0;
            ill_q    <= 1'b0;
            dat_out  <= '0;
            dat_oe   <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            ill_q    <= (state == IDLE) && rd && wrt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if ((state == IDLE) && (rd ^ wrt)) begin
                addr_q  <= add;
                data_q  <= dat_in;
                is_rd_q <= rd;
            end
            if (state == ACCESS) begin
                rdy    <= 1'b1;
                dat_oe <= is_rd_q;
                if (is_rd_q) begin
                    dat_out <= in_range ? mem_rdata[DATA_W-1:0] : '0;
                end
            end else if ((state == HOLD) && !rd && !wrt) begin
                rdy    <= 1'b0;
                dat_oe <= 1'b0;
            end
        end
    end

    s8sp_mem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_s8sp_mem_slave.sv
// tb/tb_s8sp_mem_slave.sv - two configurations driven in lockstep, checked against a countdown model
module tb_s8sp_mem_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] add = '0;
    logic [7:0] dat_in = '0;
    logic       rd = 1'b0;
    logic       wrt = 1'b0;
    logic [7:0] dout0, dout1;
    logic       oe0, oe1, rdy0, rdy1, err0, err1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    s8sp_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .add(add), .dat_in(dat_in), .dat_out(dout0),
        .dat_oe(oe0), .rd(rd), .wrt(wrt), .rdy(rdy0), .err(err0)
    );

    s8sp_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(reset), .add(add), .dat_in(dat_in), .dat_out(dout1),
        .dat_oe(oe1), .rd(rd), .wrt(wrt), .rdy(rdy1), .err(err1)
    );

    // Model: a request completes WAIT_STATES+1 edges after it is sampled.
    int         ws    [2] = '{0, 3};
    int         depth [2] = '{256, 200};
    logic [7:0] mmem  [2][256];
    bit         pbad  [2][256];
    bit         active[2];
    bit         hold  [2];
    int         rem   [2];
    bit         m_rd  [2];
    logic [7:0] m_a   [2];
    logic [7:0] m_d   [2];
    bit         exp_rdy [2];
    bit         exp_oe  [2];
    bit         exp_err [2];
    logic [7:0] exp_dout[2] = '{8'h00, 8'h00};
    bit         err_seen[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit acc_err(input int i);
        return (int'(m_a[i]) >= depth[i]) || (m_rd[i] && pbad[i][m_a[i]]);
    endfunction

    task automatic model_step(input int i);
        exp_err[i] = 1'b0;
        if (hold[i]) begin
            if (!rd && !wrt) begin
                hold[i]    = 1'b0;
                exp_rdy[i] = 1'b0;
                exp_oe[i]  = 1'b0;
            end
        end else if (active[i]) begin
            if (rem[i] > 1 && !rd && !wrt) begin
                active[i] = 1'b0;
            end else begin
                rem[i]--;
                if (rem[i] == 0) begin
                    active[i]  = 1'b0;
                    hold[i]    = 1'b1;
                    exp_rdy[i] = 1'b1;
                    exp_oe[i]  = m_rd[i];
                    if (m_rd[i]) begin
                        exp_dout[i] = (int'(m_a[i]) < depth[i]) ? mmem[i][m_a[i]] : 8'h00;
                    end else if (int'(m_a[i]) < depth[i]) begin
                        mmem[i][m_a[i]] = m_d[i];
                        pbad[i][m_a[i]] = 1'b0;
                    end
                end else if (rem[i] == 1) begin
                    exp_err[i] = acc_err(i);
                end
            end
        end else if (rd && wrt) begin
            hold[i]    = 1'b1;
            exp_err[i] = 1'b1;
        end else if (rd || wrt) begin
            active[i] = 1'b1;
            rem[i]    = ws[i] + 1;
            m_rd[i]   = rd;
            m_a[i]    = add;
            m_d[i]    = dat_in;
            if (rem[i] == 1) begin
                exp_err[i] = acc_err(i);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    active[i] = 1'b0; hold[i] = 1'b0;
                    exp_rdy[i] = 1'b0; exp_oe[i] = 1'b0; exp_err[i] = 1'b0; exp_dout[i] = 8'h00;
                end else begin
                    model_step(i);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("d0_rdy", 32'(rdy0), 32'(exp_rdy[0]));
            chk("d0_oe", 32'(oe0), 32'(exp_oe[0]));
            chk("d0_err", 32'(err0), 32'(exp_err[0]));
            chk("d0_dout", 32'(dout0), 32'(exp_dout[0]));
            chk("d1_rdy", 32'(rdy1), 32'(exp_rdy[1]));
            chk("d1_oe", 32'(oe1), 32'(exp_oe[1]));
            chk("d1_err", 32'(err1), 32'(exp_err[1]));
            chk("d1_dout", 32'(dout1), 32'(exp_dout[1]));
            if (err0) err_seen[0] = 1'b1;
            if (err1) err_seen[1] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int         lat0, lat1;
    logic [7:0] snap0, snap1;
    logic       snap_oe0, snap_oe1;

    task automatic access(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        int k = 0;
        lat0 = -1; lat1 = -1;
        rd = r; wrt = w; add = a; dat_in = d;
        if (r && w) begin
            tick(); tick();
        end else begin
            while ((lat0 < 0 || lat1 < 0) && k < 40) begin
                tick();
                k++;
                if (rdy0 && lat0 < 0) lat0 = k;
                if (rdy1 && lat1 < 0) lat1 = k;
            end
            chk("rdy_timeout", 32'(k < 40), 32'd1);
        end
        snap0 = dout0; snap1 = dout1; snap_oe0 = oe0; snap_oe1 = oe1;
        repeat ($urandom_range(0, 2)) tick();
        rd = 1'b0; wrt = 1'b0;
        add = 8'($urandom); dat_in = 8'($urandom);
        repeat ($urandom_range(1, 2)) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("reset_rdy", 32'({rdy0, rdy1}), 32'd0);
        chk("reset_oe", 32'({oe0, oe1}), 32'd0);
        chk("reset_dout", 32'({dout0, dout1}), 32'd0);
        chk("reset_err", 32'({err0, err1}), 32'd0);
        reset = 1'b1;
        tick();

        for (int a = 0; a < 256; a++) access(1'b0, 1'b1, 8'(a), 8'(a) ^ 8'h5A);

        // Zero-wait write then read back
        access(1'b0, 1'b1, 8'h10, 8'hA5);
        chk("t1_wr_lat0", 32'(lat0), 32'd2);
        chk("t1_model_mem", 32'(mmem[0][8'h10]), 32'hA5);
        access(1'b1, 1'b0, 8'h10, 8'h00);
        chk("t1_rd_lat0", 32'(lat0), 32'd2);
        chk("t1_dout0", 32'(snap0), 32'hA5);
        chk("t1_oe0", 32'(snap_oe0), 32'd1);

        // Three wait states: rdy four edges after sampling
        access(1'b0, 1'b1, 8'h20, 8'h3C);
        access(1'b1, 1'b0, 8'h20, 8'h00);
        chk("t2_lat1", 32'(lat1), 32'd5);
        chk("t2_dout1", 32'(snap1), 32'h3C);

        // Out of range on the DEPTH=200 instance
        err_seen = '{1'b0, 1'b0};
        access(1'b0, 1'b1, 8'hC8, 8'h77);
        chk("t3_wr_err1", 32'(err_seen[1]), 32'd1);
        chk("t3_wr_err0", 32'(err_seen[0]), 32'd0);
        err_seen = '{1'b0, 1'b0};
        access(1'b1, 1'b0, 8'hC8, 8'h00);
        chk("t3_rd_err1", 32'(err_seen[1]), 32'd1);
        chk("t3_rd_lat1", 32'(lat1), 32'd5);
        chk("t3_dout1", 32'(snap1), 32'h00);
        chk("t3_dout0", 32'(snap0), 32'h77);

        // Illegal request: err, no rdy, memory untouched
        err_seen = '{1'b0, 1'b0};
        access(1'b1, 1'b1, 8'h05, 8'hEE);
        chk("t4_err", 32'({err_seen[0], err_seen[1]}), 32'd3);
        chk("t4_rdy", 32'({snap_oe0, snap_oe1}), 32'd0);
        access(1'b1, 1'b0, 8'h05, 8'h00);
        chk("t4_mem0", 32'(snap0), 32'h5F);
        chk("t4_mem1", 32'(snap1), 32'h5F);

        // Reset in the second wait cycle of the 3-wait instance
        rd = 1'b0; wrt = 1'b1; add = 8'h30; dat_in = 8'hFF;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("t5_async_out", 32'({rdy0, rdy1, oe0, oe1, err0, err1, dout0, dout1}), 32'd0);
        tick();
        wrt = 1'b0;
        reset = 1'b1;
        tick();
        access(1'b1, 1'b0, 8'h30, 8'h00);
        chk("t5_mem1_kept", 32'(snap1), 32'h6A);
        chk("t5_mem0_done", 32'(snap0), 32'hFF);

`ifdef S8SP_MEM_PARITY_EN
        access(1'b0, 1'b1, 8'h40, 8'h81);
        u_dut0.u_array.mem[8'h40][8] = ~u_dut0.u_array.mem[8'h40][8];
        u_dut1.u_array.mem[8'h40][8] = ~u_dut1.u_array.mem[8'h40][8];
        pbad[0][8'h40] = 1'b1;
        pbad[1][8'h40] = 1'b1;
        err_seen = '{1'b0, 1'b0};
        access(1'b1, 1'b0, 8'h40, 8'h00);
        chk("t6_dout", 32'({snap0, snap1}), 32'h8181);
        chk("t6_err", 32'({err_seen[0], err_seen[1]}), 32'd3);
`endif

        for (int n = 0; n < 300; n++) begin
            int         op = int'($urandom_range(0, 19));
            logic [7:0] a  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(194, 206));
            if (op == 0) begin
                access(1'b1, 1'b1, a, 8'($urandom));
            end else if (op == 1) begin
                rd = $urandom_range(0, 1) == 1; wrt = !rd; add = a; dat_in = 8'($urandom);
                repeat ($urandom_range(1, 2)) tick();
                rd = 1'b0; wrt = 1'b0;
                tick(); tick();
            end else if (op == 2) begin
                wrt = 1'b1; add = a; dat_in = 8'($urandom);
                repeat ($urandom_range(1, 4)) tick();
                reset = 1'b0;
                tick();
                wrt = 1'b0;
                reset = 1'b1;
                tick();
            end else begin
                access(op < 11, op >= 11, a, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
